// File: rtl/addsub_pkg.sv
// Shared constants and elaboration helpers for the pipelined add/subtract unit.
package addsub_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int calc_stages(input int width, input int chunk);
      return width / chunk;
   endfunction

   function automatic bit chunk_fits(input int width, input int chunk);
      return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
   endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand and result handshake bundle for pipelined_addsub.
interface pipelined_addsub_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Op;
   logic             Cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Result;
   logic             Cout;
   logic             V;
   logic             Z;

   modport slave (
      input  in_valid, A, B, Op, Cin, out_ready,
      output in_ready, out_valid, Result, Cout, V, Z
   );

   modport master (
      output in_valid, A, B, Op, Cin, out_ready,
      input  in_ready, out_valid, Result, Cout, V, Z
   );
endinterface

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit adder slice; cmsb is the carry into the slice MSB,
// which the top level uses to derive signed overflow.
module addsub_chunk #(
   parameter int CHUNK = 16
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             cmsb
);
   logic [CHUNK:0] full;

   always_comb begin
      full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
      s    = full[CHUNK-1:0];
      cout = full[CHUNK];
      cmsb = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
   end
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: one CHUNK-bit slice resolved per register stage,
// whole pipeline stalls together under the valid/ready handshake.
module pipelined_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input logic               clk,
   input logic               rst_n,
   pipelined_addsub_if.slave bus
);
   localparam int STAGES = calc_stages(WIDTH, CHUNK);

   if (!chunk_fits(WIDTH, CHUNK)) begin : g_bad_chunk
      $error("pipelined_addsub: WIDTH must be a non-zero multiple of CHUNK");
   end

   logic adv;

   // Row k holds a beat whose slices below k are already resolved into res.
   logic [STAGES-1:0] vld_q, vld_d;
   logic [STAGES-1:0] op_q, op_d;
   logic [STAGES-1:0] cy_q, cy_d;
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  a_d   [STAGES];
   logic [WIDTH-1:0]  bx_q  [STAGES];
   logic [WIDTH-1:0]  bx_d  [STAGES];
   logic [WIDTH-1:0]  res_q [STAGES];
   logic [WIDTH-1:0]  res_d [STAGES];

   logic             out_vld_q, out_vld_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             cout_q, cout_d;
   logic             v_q, v_d;
   logic             z_q, z_d;

   logic [WIDTH-1:0]  s_w;
   logic [STAGES-1:0] co_w;
   logic              cm_w [STAGES];

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_slice
      addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
         .a    (a_q[gi][gi*CHUNK +: CHUNK]),
         .b    (bx_q[gi][gi*CHUNK +: CHUNK]),
         .cin  (cy_q[gi]),
         .s    (s_w[gi*CHUNK +: CHUNK]),
         .cout (co_w[gi]),
         .cmsb (cm_w[gi])
      );
   end

   always_comb begin
      adv      = !out_vld_q || bus.out_ready;

      // Subtraction is A + ~B + ~borrow, so both B and Cin are inverted up front.
      vld_d[0] = bus.in_valid;
      op_d[0]  = bus.Op;
      cy_d[0]  = (bus.Op == OP_SUB) ? ~bus.Cin : bus.Cin;
      a_d[0]   = bus.A;
      bx_d[0]  = (bus.Op == OP_SUB) ? ~bus.B : bus.B;
      res_d[0] = '0;

      for (int k = 1; k < STAGES; k++) begin
         vld_d[k] = vld_q[k-1];
         op_d[k]  = op_q[k-1];
         cy_d[k]  = co_w[k-1];
         a_d[k]   = a_q[k-1];
         bx_d[k]  = bx_q[k-1];
         res_d[k] = res_q[k-1];
         res_d[k][(k-1)*CHUNK +: CHUNK] = s_w[(k-1)*CHUNK +: CHUNK];
      end

      // Output registers only load real beats so they keep the last result
      // across bubbles.
      out_vld_d = vld_q[STAGES-1];
      result_d  = result_q;
      cout_d    = cout_q;
      v_d       = v_q;
      z_d       = z_q;
      if (vld_q[STAGES-1]) begin
         result_d = res_q[STAGES-1];
         result_d[(STAGES-1)*CHUNK +: CHUNK] = s_w[(STAGES-1)*CHUNK +: CHUNK];
         cout_d   = (op_q[STAGES-1] == OP_SUB) ? ~co_w[STAGES-1] : co_w[STAGES-1];
         v_d      = co_w[STAGES-1] ^ cm_w[STAGES-1];
         z_d      = ~|result_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q     <= '0;
         op_q      <= '0;
         cy_q      <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            bx_q[k]  <= '0;
            res_q[k] <= '0;
         end
         out_vld_q <= 1'b0;
         result_q  <= '0;
         cout_q    <= 1'b0;
         v_q       <= 1'b0;
         z_q       <= 1'b0;
      end else if (adv) begin
         vld_q     <= vld_d;
         op_q      <= op_d;
         cy_q      <= cy_d;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= a_d[k];
            bx_q[k]  <= bx_d[k];
            res_q[k] <= res_d[k];
         end
         out_vld_q <= out_vld_d;
         result_q  <= result_d;
         cout_q    <= cout_d;
         v_q       <= v_d;
         z_q       <= z_d;
      end
   end

   assign bus.in_ready  = adv;
   assign bus.out_valid = out_vld_q;
   assign bus.Result    = result_q;
   assign bus.Cout      = cout_q;
   assign bus.V         = v_q;
   assign bus.Z         = z_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: directed corner beats plus random
// traffic under random back-pressure, checked against an arithmetic model.
module tb_pipelined_addsub;
   import addsub_pkg::*;

   localparam int W = 64;

   typedef struct {
      logic [W-1:0] res;
      logic         c;
      logic         v;
      logic         z;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic rdy_q = 1'b1;
   bit   rdy_mode = 1'b0;
   bit   force_low = 1'b0;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   int   beats = 0;
   exp_t sb[$];

   pipelined_addsub_if #(.WIDTH(W)) bus ();

   pipelined_addsub #(.WIDTH(W), .CHUNK(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign bus.out_ready = rdy_q;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (force_low)     rdy_q = 1'b0;
      else if (rdy_mode) rdy_q = ($urandom_range(0, 3) != 0);
      else               rdy_q = 1'b1;
   end

   // Reference: plain wide arithmetic; overflow from the true signed sum.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic op, input logic cin);
      exp_t                e;
      logic [W:0]          u;
      logic signed [W+1:0] s;
      logic signed [W+1:0] smax;
      logic signed [W+1:0] smin;
      smax = {3'b000, {(W-1){1'b1}}};
      smin = {3'b111, {(W-1){1'b0}}};
      if (op == OP_ADD) begin
         u   = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
         e.c = u[W];
         s   = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b}) + $signed((W+2)'(cin));
      end else begin
         u   = {1'b0, a} - {1'b0, b} - (W+1)'(cin);
         e.c = ({1'b0, a} < ({1'b0, b} + (W+1)'(cin)));
         s   = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b}) - $signed((W+2)'(cin));
      end
      e.res = u[W-1:0];
      e.v   = (s > smax) || (s < smin);
      e.z   = (e.res == '0);
      return e;
   endfunction

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic op, input logic cin, output int acc);
      int n;
      n = 0;
      acc = -1;
      bus.A = a;
      bus.B = b;
      bus.Op = op;
      bus.Cin = cin;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 200) begin
         tick();
         n++;
      end
      if (!bus.in_ready) begin
         tests++;
         fails++;
         $display("FAIL issue_timeout: in_ready=%b, required 1", bus.in_ready);
         bus.in_valid = 1'b0;
         return;
      end
      sb.push_back(model(a, b, op, cin));
      acc = cyc + 1;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || bus.out_valid) && n < 300) begin
         tick();
         n++;
      end
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   function automatic logic [W-1:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return {1'b0, {(W-1){1'b1}}};
         3:       return {1'b1, {(W-1){1'b0}}};
         4:       return W'($urandom_range(0, 3));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   // Monitor: pops on every transfer, and checks hold-under-stall and hold-after-drain.
   logic [W-1:0] last_res = '0;
   logic         last_c = 1'b0, last_v = 1'b0, last_z = 1'b0;
   bit           was_stall = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         last_res  = '0;
         last_c    = 1'b0;
         last_v    = 1'b0;
         last_z    = 1'b0;
         was_stall = 1'b0;
      end else begin
         chk("in_ready", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
         if (was_stall) begin
            chk("stall_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_res", bus.Result, last_res);
         end
         if (bus.out_valid) begin
            last_res = bus.Result;
            last_c   = bus.Cout;
            last_v   = bus.V;
            last_z   = bus.Z;
            if (bus.out_ready) begin
               if (sb.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_beat: got result %h, required no beat", bus.Result);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  beats++;
                  $display("[TB] beat %0d result=%h cout=%b v=%b z=%b", beats,
                           bus.Result, bus.Cout, bus.V, bus.Z);
                  chk("result", bus.Result, e.res);
                  chk("cout", 64'(bus.Cout), 64'(e.c));
                  chk("v", 64'(bus.V), 64'(e.v));
                  chk("z", 64'(bus.Z), 64'(e.z));
               end
            end
            was_stall = !bus.out_ready;
         end else begin
            chk("drain_res", bus.Result, last_res);
            chk("drain_flags", {61'd0, bus.Cout, bus.V, bus.Z}, {61'd0, last_c, last_v, last_z});
            was_stall = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time %0t, required completion earlier", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, acc1, acc2, n;
      logic [W-1:0] all1, maxp, minn;
      all1 = '1;
      maxp = {1'b0, {(W-1){1'b1}}};
      minn = {1'b1, {(W-1){1'b0}}};

      bus.in_valid = 1'b0;
      bus.A = '0;
      bus.B = '0;
      bus.Op = OP_ADD;
      bus.Cin = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("reset_valid", 64'(bus.out_valid), 64'd0);
      chk("reset_res", bus.Result, '0);
      chk("reset_flags", {61'd0, bus.Cout, bus.V, bus.Z}, 64'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      #1 chk("ready_after_reset", 64'(bus.in_ready), 64'd1);

      // Exact latency on a simple subtract.
      issue(64'h10, 64'h3, OP_SUB, 1'b0, acc);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("latency_valid", 64'(bus.out_valid), 64'(i == 4));
      end
      chk("sub_res", bus.Result, 64'hD);
      chk("sub_flags", {61'd0, bus.Cout, bus.V, bus.Z}, 64'd0);
      drain();

      // Wrap-around and signed overflow corners, back to back.
      issue('0, '0, OP_SUB, 1'b1, acc);
      issue(all1, '0, OP_ADD, 1'b1, acc);
      issue(maxp, 64'd1, OP_ADD, 1'b0, acc);
      issue(minn, 64'd1, OP_SUB, 1'b0, acc);
      issue('0, 64'd1, OP_SUB, 1'b0, acc);
      issue(all1, 64'd1, OP_ADD, 1'b0, acc);
      drain();

      // Back-pressure: stall three cycles right after the first result.
      fork
         begin
            for (int i = 0; i < 6; i++) issue(W'(i), 64'd1, OP_ADD, 1'b0, acc);
         end
         begin
            n = 0;
            while (!bus.out_valid && n < 50) begin
               tick();
               n++;
            end
            chk("bp_first_valid", 64'(bus.out_valid), 64'd1);
            force_low = 1'b1;
            repeat (3) begin
               tick();
               chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            end
            force_low = 1'b0;
         end
      join
      drain();

      // Bubble pattern 1,0,1 in gives 1,0,1 out.
      issue(64'h1234, 64'h1111, OP_ADD, 1'b0, acc1);
      tick();
      issue(64'h5555, 64'h0AAA, OP_SUB, 1'b1, acc2);
      n = 0;
      while (cyc < acc1 + 4 && n < 20) begin
         tick();
         n++;
      end
      chk("bubble_v0", 64'(bus.out_valid), 64'd1);
      tick();
      chk("bubble_v1", 64'(bus.out_valid), 64'd0);
      tick();
      chk("bubble_v2", 64'(bus.out_valid), 64'd1);
      drain();

      // Reset with three beats in flight: none may emerge.
      issue(64'd7, 64'd8, OP_ADD, 1'b0, acc);
      issue(64'd9, 64'd1, OP_SUB, 1'b0, acc);
      issue(64'd3, 64'd3, OP_SUB, 1'b0, acc);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 64'(bus.out_valid), 64'd0);
      chk("midrst_res", bus.Result, '0);
      chk("midrst_flags", {61'd0, bus.Cout, bus.V, bus.Z}, 64'd0);
      sb.delete();
      tick();
      rst_n = 1'b1;
      #1 chk("midrst_ready", 64'(bus.in_ready), 64'd1);
      repeat (8) begin
         tick();
         chk("postrst_valid", 64'(bus.out_valid), 64'd0);
         chk("postrst_res", bus.Result, '0);
      end

      // Random traffic under random back-pressure.
      rdy_mode = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) tick();
         issue(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), acc);
      end
      rdy_mode = 1'b0;
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
